// File: rtl/fft_pkg.sv
// Shared FFT geometry for the radix-2 core and its consumers.
// Width constants plus the level-width sizing rule.
package fft_pkg;

  localparam int FFT_BW_FFTP = 4;
  localparam int FFT_BW_DATA = 18;

  // Smallest level width that holds (2*bwData)*4+3.
  function automatic int minLevelWidth(input int bwData);
    return $clog2(2 * bwData + 1) + 2;
  endfunction

endpackage

// File: rtl/fft_log2_level.sv
// Log-scale bar level: leading-one position plus two
// mantissa bits, level = (p+1)*4 + m, zero for zero.
module fft_log2_level
  import fft_pkg::*;
#(
  parameter int MagW = 36,
  parameter int LevW = 8
) (
  input  logic [MagW-1:0] Mag2,
  output logic [LevW-1:0] Level
);

  localparam int PW = $clog2(MagW);

  logic [PW-1:0]   lead;
  logic [PW:0]     expo;
  logic [MagW-1:0] norm;
  logic [1:0]      mant;

  always_comb begin
    lead = '0;
    for (int i = 0; i < MagW; i++) begin
      if (Mag2[i]) lead = PW'(i);
    end
    // Left-justify so the bits under the leading one
    // land at a fixed place; short values zero-fill.
    norm  = Mag2 << (PW'(MagW - 1) - lead);
    mant  = norm[MagW-2 -: 2];
    expo  = {1'b0, lead} + (PW + 1)'(1);
    Level = (Mag2 == '0) ? '0 : LevW'({expo, mant});
  end

endmodule

// File: rtl/fft_spectrum_reader.sv
// Sweeps the FFT RAM, turns |X|^2 into log levels and
// keeps a per-bin peak-hold with decay for the display.
module fft_spectrum_reader
  import fft_pkg::*;
#(
  parameter int bw_fftp     = FFT_BW_FFTP,
  parameter int bw_data     = FFT_BW_DATA,
  parameter int bw_level    = 8,
  parameter int fft_rd_lat  = 2,
  parameter int hold_frames = 2,
  parameter int decay_step  = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic                PeakClr,
  output logic [bw_fftp-1:0]  RdAddr,
  input  logic [bw_data-1:0]  RdData_Re,
  input  logic [bw_data-1:0]  RdData_Im,
  output logic                OutValid,
  output logic [bw_fftp-2:0]  OutBin,
  output logic [bw_level-1:0] OutLevel,
  output logic [bw_level-1:0] OutPeak,
  output logic                Busy,
  output logic                Done
);

  localparam int NBIN = 2 ** (bw_fftp - 1);
  localparam int L    = fft_rd_lat + 3;
  localparam int BB   = bw_fftp - 1;
  localparam int SW   = 2 * bw_data - 1;
  localparam int MW   = 2 * bw_data;
  localparam int CW   = $clog2(L + 1);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN
  } state_t;

  state_t state;
  logic          issueVld;
  logic [CW-1:0] drainCnt;

  logic [fft_rd_lat-1:0] vldD;
  logic [BB-1:0]         binD [fft_rd_lat];

  logic               sqVld;
  logic [BB-1:0]      sqBin;
  logic [SW-1:0]      sqRe;
  logic [SW-1:0]      sqIm;
  logic               sumVld;
  logic [BB-1:0]      sumBin;
  logic [MW-1:0]      mag2;
  logic [bw_data-1:0] absRe;
  logic [bw_data-1:0] absIm;

  logic [bw_level-1:0] level;
  logic [bw_level-1:0] curPeak;
  logic [bw_level-1:0] newPeak;
  logic [bw_level-1:0] decPeak;
  logic [7:0]          curHold;
  logic [7:0]          newHold;
  logic [bw_level-1:0] peakMem [NBIN];
  logic [7:0]          holdMem [NBIN];
  logic                clrPeaks;

  assign clrPeaks = (state == IDLE) && PeakClr;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      RdAddr   <= '0;
      issueVld <= 1'b0;
      drainCnt <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            state    <= SWEEP;
            RdAddr   <= '0;
            issueVld <= 1'b1;
            Busy     <= 1'b1;
          end
        end
        SWEEP: begin
          if (RdAddr == bw_fftp'(NBIN - 1)) begin
            state    <= DRAIN;
            issueVld <= 1'b0;
            drainCnt <= '0;
          end else begin
            RdAddr <= RdAddr + bw_fftp'(1);
          end
        end
        DRAIN: begin
          // Last bin leaves the output stage L cycles
          // after its address; Done follows it.
          if (Done) begin
            Done  <= 1'b0;
            Busy  <= 1'b0;
            state <= IDLE;
          end else if (drainCnt == CW'(L - 1)) begin
            Done <= 1'b1;
          end else begin
            drainCnt <= drainCnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign absRe = RdData_Re[bw_data-1] ? -RdData_Re : RdData_Re;
  assign absIm = RdData_Im[bw_data-1] ? -RdData_Im : RdData_Im;

  fft_log2_level #(
    .MagW(MW),
    .LevW(bw_level)
  ) uLevel (
    .Mag2 (mag2),
    .Level(level)
  );

  assign curPeak = peakMem[sumBin];
  assign curHold = holdMem[sumBin];

  always_comb begin
    newPeak = curPeak;
    newHold = curHold;
    decPeak = (curPeak > bw_level'(decay_step))
            ? curPeak - bw_level'(decay_step) : '0;
    if (level >= curPeak) begin
      newPeak = level;
      newHold = 8'(hold_frames);
    end else if (curHold != '0) begin
      newHold = curHold - 8'd1;
    end else begin
      newPeak = (decPeak > level) ? decPeak : level;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      vldD     <= '0;
      for (int k = 0; k < fft_rd_lat; k++) binD[k] <= '0;
      sqVld    <= 1'b0;
      sqBin    <= '0;
      sqRe     <= '0;
      sqIm     <= '0;
      sumVld   <= 1'b0;
      sumBin   <= '0;
      mag2     <= '0;
      OutValid <= 1'b0;
      OutBin   <= '0;
      OutLevel <= '0;
      OutPeak  <= '0;
      for (int b = 0; b < NBIN; b++) begin
        peakMem[b] <= '0;
        holdMem[b] <= '0;
      end
    end else begin
      vldD[0] <= issueVld;
      binD[0] <= RdAddr[BB-1:0];
      for (int k = 1; k < fft_rd_lat; k++) begin
        vldD[k] <= vldD[k-1];
        binD[k] <= binD[k-1];
      end
      sqVld  <= vldD[fft_rd_lat-1];
      sqBin  <= binD[fft_rd_lat-1];
      sqRe   <= SW'(absRe * absRe);
      sqIm   <= SW'(absIm * absIm);
      sumVld <= sqVld;
      sumBin <= sqBin;
      mag2   <= {1'b0, sqRe} + {1'b0, sqIm};
      OutValid <= sumVld;
      if (sumVld) begin
        OutBin          <= sumBin;
        OutLevel        <= level;
        OutPeak         <= newPeak;
        peakMem[sumBin] <= newPeak;
        holdMem[sumBin] <= newHold;
      end
      if (clrPeaks) begin
        for (int b = 0; b < NBIN; b++) begin
          peakMem[b] <= '0;
          holdMem[b] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_spectrum_reader.sv
// Directed bench for fft_spectrum_reader with a
// two-cycle FFT RAM model and hand-computed levels.
module tb_fft_spectrum_reader;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic        PeakClr;
  logic [3:0]  RdAddr;
  logic [17:0] RdData_Re;
  logic [17:0] RdData_Im;
  logic        OutValid;
  logic [2:0]  OutBin;
  logic [7:0]  OutLevel;
  logic [7:0]  OutPeak;
  logic        Busy;
  logic        Done;

  fft_spectrum_reader dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .PeakClr  (PeakClr),
    .RdAddr   (RdAddr),
    .RdData_Re(RdData_Re),
    .RdData_Im(RdData_Im),
    .OutValid (OutValid),
    .OutBin   (OutBin),
    .OutLevel (OutLevel),
    .OutPeak  (OutPeak),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 Clock = ~Clock;

  logic [17:0] ramRe [16];
  logic [17:0] ramIm [16];
  logic [17:0] d1Re;
  logic [17:0] d1Im;

  always @(posedge Clock) begin
    d1Re      <= ramRe[RdAddr];
    d1Im      <= ramIm[RdAddr];
    RdData_Re <= d1Re;
    RdData_Im <= d1Im;
  end

  int checks = 0;
  int errors = 0;

  int firstV, lastV, nV, nDone, doneAt, busyLast;
  int addrErr, binErr, nBusy;
  logic [7:0] lvl [8];
  logic [7:0] pk  [8];

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] packLvl();
    return {lvl[7], lvl[6], lvl[5], lvl[4],
            lvl[3], lvl[2], lvl[1], lvl[0]};
  endfunction

  function automatic logic [63:0] packPk();
    return {pk[7], pk[6], pk[5], pk[4],
            pk[3], pk[2], pk[1], pk[0]};
  endfunction

  task automatic runFrame(input bit clr, input int s1,
                          input int s2, input int c1);
    firstV = -1; lastV = -1; nV = 0; nDone = 0;
    doneAt = -1; busyLast = -1; addrErr = 0; binErr = 0;
    for (int i = 0; i < 8; i++) begin
      lvl[i] = 8'hff;
      pk[i]  = 8'hff;
    end
    @(posedge Clock); #1;
    Start   = 1'b1;
    PeakClr = clr;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      @(posedge Clock); #1;
      if (RdAddr !== 4'((cyc <= 8) ? cyc - 1 : 7))
        addrErr++;
      if (OutValid) begin
        if (firstV < 0) firstV = cyc;
        lastV = cyc;
        if (OutBin !== 3'(nV)) binErr++;
        lvl[OutBin] = OutLevel;
        pk[OutBin]  = OutPeak;
        nV++;
      end
      if (Done) begin
        nDone++;
        doneAt = cyc;
      end
      if (Busy) busyLast = cyc;
      Start   = (cyc == s1) || (cyc == s2);
      PeakClr = (cyc == c1);
    end
    Start   = 1'b0;
    PeakClr = 1'b0;
  endtask

  task automatic frameTiming(input string t);
    check({t, ".firstValid"}, 64'(firstV), 64'd6);
    check({t, ".lastValid"}, 64'(lastV), 64'd13);
    check({t, ".nValid"}, 64'(nV), 64'd8);
    check({t, ".nDone"}, 64'(nDone), 64'd1);
    check({t, ".doneAt"}, 64'(doneAt), 64'd14);
    check({t, ".busyLast"}, 64'(busyLast), 64'd14);
    check({t, ".addrSeq"}, 64'(addrErr), 64'd0);
    check({t, ".binSeq"}, 64'(binErr), 64'd0);
  endtask

  initial begin
    Reset   = 1'b0;
    Start   = 1'b0;
    PeakClr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ramRe[i] = '0;
      ramIm[i] = '0;
    end
    repeat (2) @(posedge Clock);
    #1;
    check("rst.outs",
          64'({RdAddr, OutValid, OutBin, OutLevel,
               OutPeak, Busy, Done}), 64'd0);
    Reset = 1'b1;
    @(posedge Clock); #1;

    // 1: zero spectrum
    runFrame(1'b0, 0, 0, 0);
    frameTiming("t1");
    check("t1.levels", packLvl(), 64'd0);
    check("t1.peaks", packPk(), 64'd0);

    // 2: level conversion
    ramRe[1] = 18'd1;
    ramRe[2] = 18'd3;
    ramRe[3] = -18'sd3;
    ramIm[3] = 18'd4;
    ramRe[7] = 18'h20000;
    ramIm[7] = 18'h20000;
    runFrame(1'b0, 0, 0, 0);
    frameTiming("t2");
    check("t2.levels", packLvl(),
          {8'd144, 8'd0, 8'd0, 8'd0,
           8'd22, 8'd16, 8'd4, 8'd0});
    check("t2.peaks", packPk(),
          {8'd144, 8'd0, 8'd0, 8'd0,
           8'd22, 8'd16, 8'd4, 8'd0});

    // 3/4: hold then decay; PeakClr during SWEEP
    ramRe[3] = 18'd1;
    ramIm[3] = 18'd0;
    runFrame(1'b0, 0, 0, 3);
    check("f3.lvl3", 64'(lvl[3]), 64'd4);
    check("f3.pk3", 64'(pk[3]), 64'd22);
    check("f3.pk7", 64'(pk[7]), 64'd144);

    runFrame(1'b0, 4, 11, 0);
    frameTiming("f4.restart");
    check("f4.pk3", 64'(pk[3]), 64'd22);

    runFrame(1'b0, 0, 0, 0);
    check("f5.pk3", 64'(pk[3]), 64'd21);

    runFrame(1'b0, 0, 0, 0);
    check("f6.pk3", 64'(pk[3]), 64'd20);
    check("f6.lvl3", 64'(lvl[3]), 64'd4);

    // PeakClr in IDLE
    @(posedge Clock); #1;
    PeakClr = 1'b1;
    @(posedge Clock); #1;
    PeakClr = 1'b0;
    runFrame(1'b0, 0, 0, 0);
    check("f7.peaks", packPk(),
          {8'd144, 8'd0, 8'd0, 8'd0,
           8'd4, 8'd16, 8'd4, 8'd0});

    // PeakClr together with Start
    ramRe[7] = 18'd0;
    ramIm[7] = 18'd0;
    runFrame(1'b1, 0, 0, 0);
    frameTiming("f8");
    check("f8.pk7", 64'(pk[7]), 64'd0);
    check("f8.pk3", 64'(pk[3]), 64'd4);

    ramRe[7] = 18'h20000;
    ramIm[7] = 18'h20000;
    runFrame(1'b0, 0, 0, 0);
    check("f9.pk7", 64'(pk[7]), 64'd144);

    // 5: reset mid-SWEEP
    ramRe[7] = 18'd1;
    ramIm[7] = 18'd0;
    @(posedge Clock); #1;
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("t5.preBusy", 64'(Busy), 64'd1);
    check("t5.preAddr", 64'(RdAddr), 64'd2);
    Reset = 1'b0;
    #1;
    check("t5.asyncOuts",
          64'({RdAddr, OutValid, OutBin, OutLevel,
               OutPeak, Busy, Done}), 64'd0);
    nDone = 0;
    nBusy = 0;
    repeat (3) begin
      @(posedge Clock); #1;
      if (Done) nDone++;
      if (Busy) nBusy++;
    end
    Reset = 1'b1;
    repeat (20) begin
      @(posedge Clock); #1;
      if (Done) nDone++;
      if (Busy) nBusy++;
    end
    check("t5.noDone", 64'(nDone), 64'd0);
    check("t5.noBusy", 64'(nBusy), 64'd0);

    runFrame(1'b0, 0, 0, 0);
    frameTiming("t5.clean");
    check("t5.levels", packLvl(),
          {8'd4, 8'd0, 8'd0, 8'd0,
           8'd4, 8'd16, 8'd4, 8'd0});
    check("t5.peaks", packPk(),
          {8'd4, 8'd0, 8'd0, 8'd0,
           8'd4, 8'd16, 8'd4, 8'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
